// File: rtl/network_interface_if.sv
// Core/router-facing signal bundle of the mesh network interface.
// The NI uses the master view; the core plus router environment uses the slave view.
interface network_interface_if;
   logic [31:0] tx_flit_data;
   logic        tx_flit_wr;
   logic        tx_send;
   logic        tx_busy;
   logic        tx_done;
   logic        tx_error;
   logic [31:0] data_out;
   logic        write_out_signal;
   logic [2:0]  capacity_in;
   logic        ack_in;
   logic [31:0] data_in;
   logic        write_in_signal;
   logic [2:0]  capacity_out;
   logic        ack_out;
   logic        rx_pkt_valid;
   logic [2:0]  rx_rd_idx;
   logic [31:0] rx_rd_data;
   logic        rx_release;

   modport master (
      input  tx_flit_data, tx_flit_wr, tx_send, capacity_in, ack_in,
             data_in, write_in_signal, rx_rd_idx, rx_release,
      output tx_busy, tx_done, tx_error, data_out, write_out_signal,
             capacity_out, ack_out, rx_pkt_valid, rx_rd_data
   );

   modport slave (
      output tx_flit_data, tx_flit_wr, tx_send, capacity_in, ack_in,
             data_in, write_in_signal, rx_rd_idx, rx_release,
      input  tx_busy, tx_done, tx_error, data_out, write_out_signal,
             capacity_out, ack_out, rx_pkt_valid, rx_rd_data
   );
endinterface

// File: rtl/network_interface.sv
// Local-port endpoint of a mesh node: stages and injects TX packets with
// ack/timeout/retry, and assembles one RX packet at a time for the core.
module network_interface #(
   parameter int MY_ID       = 0,
   parameter int MAX_FLITS   = 5,
   parameter int ACK_TIMEOUT = 16,
   parameter int MAX_RETRY   = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   network_interface_if.master  ni
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam logic [4:0] MY_ID_BITS = 5'(MY_ID);
   localparam logic [2:0] MAXF       = 3'(MAX_FLITS);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_WAIT_CAP,
      TX_SEND,
      TX_WAIT_ACK
   } tx_state_t;

   // ---------------- TX ----------------
   tx_state_t      state_reg, state_next;
   logic [31:0]    tx_buf_reg [MAX_FLITS];
   logic [2:0]     tx_wr_ptr_reg;
   logic [2:0]     tx_size_reg;
   logic [2:0]     flit_idx_reg;
   logic [TW-1:0]  timer_reg;
   logic [RW-1:0]  retry_cnt_reg;
   logic           tx_done_reg;
   logic           tx_error_reg;

   logic [2:0]           hdr_size;
   logic                 size_ok;
   logic                 send_req;
   logic                 send_go;
   logic                 send_bad;
   logic                 tx_stage;
   logic [31:0]          tx_stage_data;
   logic [MAX_FLITS-1:0] tx_we;
   logic                 ack_hit;
   logic                 timer_done;
   logic                 retry_ok;
   logic                 give_up;
   logic                 last_flit;

   assign hdr_size   = tx_buf_reg[0][24:22];
   assign size_ok    = (hdr_size != 3'd0) && (hdr_size <= MAXF);
   assign send_req   = (state_reg == TX_IDLE) && ni.tx_send && (tx_wr_ptr_reg != 3'd0);
   assign send_go    = send_req && size_ok;
   assign send_bad   = send_req && !size_ok;
   assign tx_stage   = (state_reg == TX_IDLE) && ni.tx_flit_wr && (tx_wr_ptr_reg < MAXF);
   assign ack_hit    = (state_reg == TX_WAIT_ACK) && ni.ack_in;
   assign timer_done = (state_reg == TX_WAIT_ACK) && !ni.ack_in &&
                       (timer_reg == TW'(ACK_TIMEOUT - 1));
   assign retry_ok   = retry_cnt_reg < RW'(MAX_RETRY);
   assign give_up    = timer_done && !retry_ok;
   assign last_flit  = flit_idx_reg == (tx_size_reg - 3'd1);

   // The source id is stamped when the header is staged, so every resend carries it.
   assign tx_stage_data = (tx_wr_ptr_reg == 3'd0) ?
                          {ni.tx_flit_data[31:22], MY_ID_BITS, ni.tx_flit_data[16:0]} :
                          ni.tx_flit_data;

   genvar gi;
   generate
      for (gi = 0; gi < MAX_FLITS; gi++) begin : g_tx_we
         assign tx_we[gi] = tx_stage && (tx_wr_ptr_reg == 3'(gi));
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_reg <= TX_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         TX_IDLE:     if (send_go) state_next = TX_WAIT_CAP;
         TX_WAIT_CAP: if (ni.capacity_in >= tx_size_reg) state_next = TX_SEND;
         TX_SEND:     if (last_flit) state_next = TX_WAIT_ACK;
         TX_WAIT_ACK: begin
            if (ni.ack_in)        state_next = TX_IDLE;
            else if (timer_done)  state_next = retry_ok ? TX_WAIT_CAP : TX_IDLE;
         end
         default:     state_next = TX_IDLE;
      endcase
   end

   always_comb begin
      ni.tx_busy          = state_reg != TX_IDLE;
      ni.write_out_signal = 1'b0;
      ni.data_out         = '0;
      if (state_reg == TX_SEND) begin
         ni.write_out_signal = 1'b1;
         ni.data_out         = tx_buf_reg[flit_idx_reg];
      end
   end

   assign ni.tx_done  = tx_done_reg;
   assign ni.tx_error = tx_error_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_wr_ptr_reg <= '0;
         tx_size_reg   <= '0;
         flit_idx_reg  <= '0;
         timer_reg     <= '0;
         retry_cnt_reg <= '0;
         tx_done_reg   <= 1'b0;
         tx_error_reg  <= 1'b0;
         for (int i = 0; i < MAX_FLITS; i++) tx_buf_reg[i] <= '0;
      end else begin
         tx_done_reg  <= ack_hit;
         tx_error_reg <= send_bad || give_up;

         for (int i = 0; i < MAX_FLITS; i++)
            if (tx_we[i]) tx_buf_reg[i] <= tx_stage_data;

         if (tx_stage)
            tx_wr_ptr_reg <= tx_wr_ptr_reg + 3'd1;
         else if (ack_hit || give_up)
            tx_wr_ptr_reg <= '0;

         if (send_go) begin
            tx_size_reg   <= hdr_size;
            retry_cnt_reg <= '0;
         end else if (timer_done && retry_ok) begin
            retry_cnt_reg <= retry_cnt_reg + RW'(1);
         end

         if (state_reg == TX_WAIT_CAP)  flit_idx_reg <= '0;
         else if (state_reg == TX_SEND) flit_idx_reg <= flit_idx_reg + 3'd1;

         if (state_reg == TX_WAIT_ACK) timer_reg <= timer_reg + TW'(1);
         else                          timer_reg <= '0;
      end
   end

   // ---------------- RX ----------------
   logic [31:0]          rx_buf_reg [MAX_FLITS];
   logic [2:0]           rx_cnt_reg, rx_cnt_next;
   logic [2:0]           rx_size_reg;
   logic                 rx_pkt_valid_reg, rx_pkt_valid_next;
   logic [2:0]           capacity_out_reg;
   logic                 ack_out_reg;

   logic [2:0]           rx_hdr_size;
   logic                 rx_hdr_ok;
   logic                 rx_complete;
   logic                 rx_accept;
   logic                 rx_release_go;
   logic [MAX_FLITS-1:0] rx_we;

   assign rx_hdr_size   = ni.data_in[24:22];
   assign rx_hdr_ok     = (rx_hdr_size != 3'd0) && (rx_hdr_size <= MAXF);
   assign rx_complete   = (rx_cnt_reg != 3'd0) && (rx_cnt_reg == rx_size_reg);
   // Flits beyond a complete packet are router protocol violations and are dropped.
   assign rx_accept     = ni.write_in_signal && !rx_pkt_valid_reg && !rx_complete &&
                          (rx_cnt_reg < MAXF) && ((rx_cnt_reg != 3'd0) || rx_hdr_ok);
   assign rx_release_go = ni.rx_release && rx_pkt_valid_reg;

   generate
      for (gi = 0; gi < MAX_FLITS; gi++) begin : g_rx_we
         assign rx_we[gi] = rx_accept && (rx_cnt_reg == 3'(gi));
      end
   endgenerate

   always_comb begin
      rx_cnt_next       = rx_cnt_reg;
      rx_pkt_valid_next = rx_pkt_valid_reg;
      if (rx_release_go) begin
         rx_cnt_next       = '0;
         rx_pkt_valid_next = 1'b0;
      end else begin
         if (rx_accept)   rx_cnt_next       = rx_cnt_reg + 3'd1;
         if (rx_complete) rx_pkt_valid_next = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_cnt_reg       <= '0;
         rx_size_reg      <= '0;
         rx_pkt_valid_reg <= 1'b0;
         capacity_out_reg <= MAXF;
         ack_out_reg      <= 1'b0;
         for (int i = 0; i < MAX_FLITS; i++) rx_buf_reg[i] <= '0;
      end else begin
         rx_cnt_reg       <= rx_cnt_next;
         rx_pkt_valid_reg <= rx_pkt_valid_next;
         capacity_out_reg <= rx_pkt_valid_next ? 3'd0 : (MAXF - rx_cnt_next);
         ack_out_reg      <= rx_release_go;
         if (rx_accept && (rx_cnt_reg == 3'd0)) rx_size_reg <= rx_hdr_size;
         for (int i = 0; i < MAX_FLITS; i++)
            if (rx_we[i]) rx_buf_reg[i] <= ni.data_in;
      end
   end

   assign ni.capacity_out = capacity_out_reg;
   assign ni.ack_out      = ack_out_reg;
   assign ni.rx_pkt_valid = rx_pkt_valid_reg;

   always_comb begin
      ni.rx_rd_data = '0;
      if (ni.rx_rd_idx < MAXF) ni.rx_rd_data = rx_buf_reg[ni.rx_rd_idx];
   end

endmodule
